// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, fetches over imem req/ack, presents ins with valid/ready; min 2 cycles/instr.
// Decode backpressure holds ins/pc in HOLD. Optional IFU_MISALIGN_TRAP_EN halts on a misaligned npc.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      npc,
  output logic [31:0]      pc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [31:0]      ins,
  output logic [31:0]      ins_pc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             misalign
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc_next;
  logic        accept;
  logic        npc_bad;
  logic        misalign_q;

  // Outputs decode only registered state, so no input reaches them combinationally.
  assign imem_req  = (state == REQ);
  assign ins_valid = (state == HOLD);
  assign imem_addr = pc;
  assign accept    = (state == HOLD) && ins_ready;
  assign pc_next   = npc & ~32'h3;

`ifdef IFU_MISALIGN_TRAP_EN
  assign npc_bad  = (npc[1:0] != 2'b00);
  assign misalign = misalign_q;
`else
  assign npc_bad  = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ins        <= 32'h0;
      ins_pc     <= 32'h0;
      fetch_cnt  <= '0;
      misalign_q <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ: begin
          if (imem_ack) begin
            ins    <= imem_rdata;
            ins_pc <= pc;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            fetch_cnt <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            // A trapped npc leaves pc pointing at the instruction that produced it.
            if (npc_bad) begin
              misalign_q <= 1'b1;
              state      <= HALT;
            end else begin
              pc    <= pc_next;
              state <= REQ;
            end
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule
